// File: rtl/muldiv_unit.sv
// muldiv_unit: execute-stage multiply/divide unit holding the HI/LO registers.
// One operation is launched per start pulse while idle; busy stays high for a
// fixed MUL_CYCLES / DIV_CYCLES latency and the result is committed to HI/LO
// in the cycle busy falls. Pipeline hazard logic stalls on busy.
//
// Optional build macro: MULDIV_MADD_EN enables madd/maddu (ops 4/5), which
// accumulate a product into {hi,lo}. Without it ops 4/5 are reserved.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset, clears all state
//   start  - one-cycle launch pulse from E stage
//   op     - 0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6-7 reserved
//   a, b   - forwarded rs / rt operands (a is also the mthi/mtlo data)
//   hi_we  - mthi strobe, honoured only when idle and start is low
//   lo_we  - mtlo strobe, honoured only when idle and start is low
//   busy   - operation in flight
//   hi, lo - HI / LO registers
//
// state | meaning
// IDLE  | no operation in flight, busy=0, mthi/mtlo accepted
// RUN   | operation in flight, counter counts down to the commit edge

module muldiv_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  count;
    logic [31:0] resHi;
    logic [31:0] resLo;
    logic        skipCommit;

    logic        opLegal;
    logic        isDiv;
    logic [63:0] mulS;
    logic [63:0] mulU;
    logic [31:0] divQ;
    logic [31:0] divR;
    logic [31:0] divuQ;
    logic [31:0] divuR;
    logic [31:0] nextHi;
    logic [31:0] nextLo;

`ifdef MULDIV_MADD_EN
    logic accumulate;
`endif

    always_comb begin
        opLegal = 1'b0;
        case (op)
            3'd0, 3'd1, 3'd2, 3'd3: opLegal = 1'b1;
`ifdef MULDIV_MADD_EN
            3'd4, 3'd5:             opLegal = 1'b1;
`endif
            default:                opLegal = 1'b0;
        endcase
        isDiv = (op == 3'd2) || (op == 3'd3);

        mulS = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        mulU = {32'b0, a} * {32'b0, b};

        divQ  = '0;
        divR  = '0;
        divuQ = '0;
        divuR = '0;
        if (b != 32'd0) begin
            // -2^31 / -1 overflows; the architected result wraps instead of trapping.
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                divQ = a;
                divR = '0;
            end else begin
                divQ = $signed(a) / $signed(b);
                divR = $signed(a) % $signed(b);
            end
            divuQ = a / b;
            divuR = a % b;
        end

        case (op)
            3'd0, 3'd4: {nextHi, nextLo} = mulS;
            3'd1, 3'd5: {nextHi, nextLo} = mulU;
            3'd2:       {nextHi, nextLo} = {divR, divQ};
            3'd3:       {nextHi, nextLo} = {divuR, divuQ};
            default:    {nextHi, nextLo} = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            count      <= '0;
            resHi      <= '0;
            resLo      <= '0;
            skipCommit <= 1'b0;
            hi         <= '0;
            lo         <= '0;
`ifdef MULDIV_MADD_EN
            accumulate <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start && opLegal) begin
                        resHi      <= nextHi;
                        resLo      <= nextLo;
                        count      <= isDiv ? DIV_LOAD : MUL_LOAD;
                        skipCommit <= isDiv && (b == 32'd0);
`ifdef MULDIV_MADD_EN
                        accumulate <= op[2];
`endif
                        state      <= RUN;
                        busy       <= 1'b1;
                    end else if (!start) begin
                        if (hi_we) hi <= a;
                        if (lo_we) lo <= a;
                    end
                end
                RUN: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!skipCommit) begin
`ifdef MULDIV_MADD_EN
                            // Accumulator is read at the commit edge; HI/LO are frozen during RUN.
                            if (accumulate)
                                {hi, lo} <= {hi, lo} + {resHi, resLo};
                            else
                                {hi, lo} <= {resHi, resLo};
`else
                            {hi, lo} <= {resHi, resLo};
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;
`ifdef MULDIV_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hiWe = 1'b0;
    logic        loWe = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;

    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hiWe), .lo_we(loWe), .busy(busy), .hi(hi), .lo(lo)
    );

    // Reference model: architectural effect of one operation on {mHi,mLo};
    // returns the expected busy length (0 for an ignored start).
    function automatic int modelOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy;
        logic [63:0] prod;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'd0: begin prod = sx * sy; {mHi, mLo} = prod; return MUL_N; end
            3'd1: begin prod = ux * uy; {mHi, mLo} = prod; return MUL_N; end
            3'd2: begin
                if (y == 0) return DIV_N;
                q = sx / sy; r = sx % sy;
                mLo = q[31:0]; mHi = r[31:0];
                return DIV_N;
            end
            3'd3: begin
                if (y == 0) return DIV_N;
                mLo = 32'(ux / uy); mHi = 32'(ux % uy);
                return DIV_N;
            end
            3'd4: begin
                if (!MADD) return 0;
                prod = sx * sy; {mHi, mLo} = {mHi, mLo} + prod; return MUL_N;
            end
            3'd5: begin
                if (!MADD) return 0;
                prod = ux * uy; {mHi, mLo} = {mHi, mLo} + prod; return MUL_N;
            end
            default: return 0;
        endcase
    endfunction

    task automatic writeHi(input logic [31:0] v);
        @(negedge clk); a = v; hiWe = 1'b1;
        @(negedge clk); hiWe = 1'b0;
        mHi = v;
    endtask

    task automatic writeLo(input logic [31:0] v);
        @(negedge clk); a = v; loWe = 1'b1;
        @(negedge clk); loWe = 1'b0;
        mLo = v;
    endtask

    task automatic runOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string name);
        int expN, n, guard;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        expN = modelOp(o, x, y);
        @(negedge clk);
        start = 1'b0;
        n = 0; guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            n++; guard++;
            @(negedge clk);
        end
        total++;
        if (n !== expN) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, n, expN); end
        total++;
        if (hi !== mHi) begin bad++; $display("FAIL %s hi got=%h exp=%h", name, hi, mHi); end
        total++;
        if (lo !== mLo) begin bad++; $display("FAIL %s lo got=%h exp=%h", name, lo, mLo); end
    endtask

    task automatic test_reset();
        int seen;
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++; $display("FAIL reset_init busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
        end
        @(negedge clk); reset = 1'b1;
        writeHi(32'h5555_AAAA);
        writeLo(32'h1234_5678);
        @(negedge clk);
        op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++; $display("FAIL reset_midrun busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
        end
        mHi = '0; mLo = '0;
        @(negedge clk); reset = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL reset_idle busy_high_cycles got=%0d exp=0", seen); end
        total++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            bad++; $display("FAIL reset_idle hi=%h lo=%h exp 0/0", hi, lo);
        end
    endtask

    task automatic test_mult();
        runOp(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, "mult");
        total++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            bad++; $display("FAIL mult_const hi=%h lo=%h exp ffffffff/fffffffa", hi, lo);
        end
        runOp(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, "multu");
        total++;
        if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
            bad++; $display("FAIL multu_const hi=%h lo=%h exp 00000002/fffffffa", hi, lo);
        end
    endtask

    task automatic test_div();
        runOp(3'd2, 32'hFFFF_FFF9, 32'd2, "div");
        total++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            bad++; $display("FAIL div_const hi=%h lo=%h exp ffffffff/fffffffd", hi, lo);
        end
        runOp(3'd3, 32'd7, 32'd2, "divu");
        total++;
        if (hi !== 32'd1 || lo !== 32'd3) begin
            bad++; $display("FAIL divu_const hi=%h lo=%h exp 1/3", hi, lo);
        end
        runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        total++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            bad++; $display("FAIL div_overflow_const hi=%h lo=%h exp 0/80000000", hi, lo);
        end
        writeHi(32'h11);
        writeLo(32'h22);
        runOp(3'd2, 32'd1234, 32'd0, "div_by_zero");
        runOp(3'd3, 32'd99, 32'd0, "divu_by_zero");
        total++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            bad++; $display("FAIL divz_const hi=%h lo=%h exp 11/22", hi, lo);
        end
    endtask

    task automatic test_mthi_mtlo();
        int n, k, expN;
        logic [31:0] oldLo;
        writeHi(32'hDEAD_BEEF);
        total++;
        if (hi !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mthi got=%h exp=deadbeef", hi); end
        @(negedge clk); a = 32'hCAFE_F00D; hiWe = 1'b1; loWe = 1'b1;
        @(negedge clk); hiWe = 1'b0; loWe = 1'b0;
        mHi = 32'hCAFE_F00D; mLo = 32'hCAFE_F00D;
        total++;
        if (hi !== mHi || lo !== mLo) begin
            bad++; $display("FAIL mt_both hi=%h lo=%h exp %h/%h", hi, lo, mHi, mLo);
        end
        // lo_we while busy is dropped, and lo holds its old value until commit
        oldLo = mLo;
        @(negedge clk); op = 3'd0; a = 32'd9; b = 32'd11; start = 1'b1;
        expN = modelOp(3'd0, 32'd9, 32'd11);
        @(negedge clk); start = 1'b0;
        n = 0; k = 0;
        while (busy === 1'b1 && k < 40) begin
            n++;
            if (k == 1) begin a = 32'h0BAD_0BAD; loWe = 1'b1; end
            else loWe = 1'b0;
            if (k == 3) begin
                total++;
                if (lo !== oldLo) begin bad++; $display("FAIL lo_hold_midop got=%h exp=%h", lo, oldLo); end
            end
            k++;
            @(negedge clk);
        end
        loWe = 1'b0;
        total++;
        if (n !== expN || lo !== mLo || hi !== mHi) begin
            bad++; $display("FAIL mtlo_busy n=%0d lo=%h hi=%h exp %0d/%h/%h", n, lo, hi, expN, mLo, mHi);
        end
        // lo_we together with start: the operation wins
        @(negedge clk); op = 3'd1; a = 32'd6; b = 32'd7; start = 1'b1; loWe = 1'b1;
        expN = modelOp(3'd1, 32'd6, 32'd7);
        @(negedge clk); start = 1'b0; loWe = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
        total++;
        if (n !== expN || lo !== 32'd42 || hi !== 32'd0) begin
            bad++; $display("FAIL mtlo_with_start n=%0d lo=%h hi=%h exp %0d/0000002a/0", n, lo, hi, expN);
        end
    endtask

    task automatic test_back_to_back_start();
        int n, k, expN;
        @(negedge clk); op = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1;
        expN = modelOp(3'd0, 32'd3, 32'd5);
        @(negedge clk); start = 1'b0;
        n = 0; k = 0;
        while (busy === 1'b1 && k < 40) begin
            n++;
            if (k == 1) begin op = 3'd0; a = 32'd0; b = 32'd0; start = 1'b1; end
            else start = 1'b0;
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (n !== expN || lo !== 32'd15 || hi !== 32'd0) begin
            bad++; $display("FAIL start_while_busy n=%0d hi=%h lo=%h exp %0d/0/f", n, hi, lo, expN);
        end
    endtask

    task automatic test_madd_reserved();
        writeHi(32'd0);
        writeLo(32'hFFFF_FFFF);
        runOp(3'd5, 32'd1, 32'd1, "maddu");
        writeHi(32'h0000_0010);
        writeLo(32'h0000_0020);
        runOp(3'd4, 32'hFFFF_FFFF, 32'd3, "madd");
        runOp(3'd6, 32'd5, 32'd5, "reserved6");
        runOp(3'd7, 32'd5, 32'd5, "reserved7");
    endtask

    task automatic test_random();
        logic [2:0] o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) o = 3'($urandom_range(6, 7));
            else o = 3'($urandom_range(0, MADD ? 5 : 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'($urandom_range(0, 50)); y = 32'($urandom_range(1, 9)); end
                2: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            if ($urandom_range(0, 4) == 0) writeHi($urandom);
            if ($urandom_range(0, 4) == 0) writeLo($urandom);
            runOp(o, x, y, "random");
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_back_to_back_start();
        test_madd_reserved();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
